// File: rtl/snoop_responder_if.sv
// rtl/snoop_responder_if.sv - snoop command, tag lookup, result, writeback and MESI update signals
interface snoop_responder_if;
    logic        snoop_valid;
    logic [3:0]  snoop_op;
    logic [31:0] snoop_addr;
    logic        snoop_ready;
    logic        lookup_req;
    logic [13:0] lookup_index;
    logic [11:0] lookup_tag;
    logic        lookup_ack;
    logic        lookup_hit;
    logic [2:0]  lookup_way;
    logic [1:0]  lookup_mesi;
    logic        result_valid;
    logic [1:0]  snoop_result;
    logic        wb_req;
    logic [31:0] wb_addr;
    logic        wb_ack;
    logic        upd_valid;
    logic [2:0]  upd_way;
    logic [1:0]  upd_mesi;

    modport slave (
        input  snoop_valid, snoop_op, snoop_addr, lookup_ack, lookup_hit, lookup_way,
               lookup_mesi, wb_ack,
        output snoop_ready, lookup_req, lookup_index, lookup_tag, result_valid,
               snoop_result, wb_req, wb_addr, upd_valid, upd_way, upd_mesi
    );

    modport master (
        output snoop_valid, snoop_op, snoop_addr, lookup_ack, lookup_hit, lookup_way,
               lookup_mesi, wb_ack,
        input  snoop_ready, lookup_req, lookup_index, lookup_tag, result_valid,
               snoop_result, wb_req, wb_addr, upd_valid, upd_way, upd_mesi
    );
endinterface

// File: rtl/snoop_responder.sv
// rtl/snoop_responder.sv - MESI snoop responder for the 8-way data cache
// Optional protocol checking (proto_err port) is enabled by defining SNOOP_CHECK_EN.
module snoop_responder (
    input  logic               clk,
    input  logic               rst,
    snoop_responder_if.slave   bus,
    output logic [15:0]        cnt_hit,
    output logic [15:0]        cnt_hitm,
    output logic [15:0]        cnt_nohit
`ifdef SNOOP_CHECK_EN
    ,
    output logic               proto_err
`endif
);
    localparam int SETS       = 16384;
    localparam int WAYS       = 8;
    localparam int INDEX_W    = $clog2(SETS);
    localparam int WAY_W      = $clog2(WAYS);
    localparam int OFFSET_W   = 6;
    localparam int TAG_W      = 32 - INDEX_W - OFFSET_W;

    localparam logic [1:0] RES_NOHIT = 2'd0;
    localparam logic [1:0] RES_HIT   = 2'd1;
    localparam logic [1:0] RES_HITM  = 2'd2;

    typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_t;
    typedef enum logic [2:0] {IDLE, LOOKUP, RESPOND, WRITEBACK, UPDATE} state_t;

    state_t             state;
    logic [3:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] index_q;
    logic [1:0]         result_q;
    logic               upd_need;
    logic [WAY_W-1:0]   upd_way_q;
    mesi_t              upd_mesi_q;

    mesi_t              cur_mesi;
    logic               hit_eff;
    logic [1:0]         lk_result;
    logic               lk_upd;
    mesi_t              lk_mesi;
    logic               unused_offset;

    assign unused_offset = ^bus.snoop_addr[OFFSET_W-1:0];
    assign cur_mesi      = mesi_t'(bus.lookup_mesi);
    assign hit_eff       = bus.lookup_hit && (cur_mesi != MESI_I);

    // Outcome of a completed lookup; misses and I lines fall through to NOHIT.
    always_comb begin
        lk_result = RES_NOHIT;
        lk_upd    = 1'b0;
        lk_mesi   = cur_mesi;
        if (hit_eff) begin
            case (op_q)
                4'd3: begin
                    lk_result = (cur_mesi == MESI_M) ? RES_HITM : RES_HIT;
                    lk_upd    = (cur_mesi != MESI_S);
                    lk_mesi   = MESI_S;
                end
                4'd5: begin
                    lk_result = (cur_mesi == MESI_M) ? RES_HITM : RES_HIT;
                    lk_upd    = 1'b1;
                    lk_mesi   = MESI_I;
                end
                4'd6: begin
                    if (cur_mesi == MESI_S) begin
                        lk_result = RES_HIT;
                        lk_upd    = 1'b1;
                        lk_mesi   = MESI_I;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.snoop_ready  = (state == IDLE);
    assign bus.lookup_req   = (state == LOOKUP);
    assign bus.result_valid = (state == RESPOND);
    assign bus.wb_req       = (state == WRITEBACK);
    assign bus.upd_valid    = (state == UPDATE);
    assign bus.lookup_index = index_q;
    assign bus.lookup_tag   = tag_q;
    assign bus.snoop_result = result_q;
    assign bus.wb_addr      = {tag_q, index_q, {OFFSET_W{1'b0}}};
    assign bus.upd_way      = upd_way_q;
    assign bus.upd_mesi     = upd_mesi_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            op_q       <= '0;
            tag_q      <= '0;
            index_q    <= '0;
            result_q   <= RES_NOHIT;
            upd_need   <= 1'b0;
            upd_way_q  <= '0;
            upd_mesi_q <= MESI_I;
            cnt_hit    <= '0;
            cnt_hitm   <= '0;
            cnt_nohit  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.snoop_valid) begin
                        op_q    <= bus.snoop_op;
                        tag_q   <= bus.snoop_addr[31 -: TAG_W];
                        index_q <= bus.snoop_addr[OFFSET_W +: INDEX_W];
                        case (bus.snoop_op)
                            4'd3, 4'd5, 4'd6: state <= LOOKUP;
                            4'd4: begin
                                result_q <= RES_NOHIT;
                                upd_need <= 1'b0;
                                state    <= RESPOND;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                LOOKUP: begin
                    if (bus.lookup_ack) begin
                        result_q   <= lk_result;
                        upd_need   <= lk_upd;
                        upd_way_q  <= bus.lookup_way;
                        upd_mesi_q <= lk_mesi;
                        state      <= RESPOND;
                    end
                end
                RESPOND: begin
                    case (result_q)
                        RES_HIT:  if (cnt_hit   != 16'hFFFF) cnt_hit   <= cnt_hit + 16'd1;
                        RES_HITM: if (cnt_hitm  != 16'hFFFF) cnt_hitm  <= cnt_hitm + 16'd1;
                        default:  if (cnt_nohit != 16'hFFFF) cnt_nohit <= cnt_nohit + 16'd1;
                    endcase
                    if (result_q == RES_HITM)
                        state <= WRITEBACK;
                    else if (upd_need)
                        state <= UPDATE;
                    else
                        state <= IDLE;
                end
                WRITEBACK: if (bus.wb_ack) state <= UPDATE;
                UPDATE:    state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

`ifdef SNOOP_CHECK_EN
    logic err_set;

    assign err_set =
        ((state == IDLE) && bus.snoop_valid &&
         !(bus.snoop_op inside {4'd3, 4'd4, 4'd5, 4'd6})) ||
        ((state == LOOKUP) && bus.lookup_ack &&
         (((op_q == 4'd6) && bus.lookup_hit &&
           (cur_mesi == MESI_E || cur_mesi == MESI_M)) ||
          (!bus.lookup_hit && (cur_mesi == MESI_E || cur_mesi == MESI_M))));

    always_ff @(posedge clk) begin
        if (!rst) begin
            proto_err <= 1'b0;
        end else if (err_set) begin
            proto_err <= 1'b1;
            $error("snoop_responder: protocol violation (state %0d, op %0d)", state, op_q);
        end
    end
`endif
endmodule

// File: tb/tb_snoop_responder.sv
// tb/tb_snoop_responder.sv - directed self-checking bench for snoop_responder
module tb_snoop_responder;
    logic        clk;
    logic        rst;
    logic [15:0] cnt_hit, cnt_hitm, cnt_nohit;
`ifdef SNOOP_CHECK_EN
    logic        proto_err;
`endif
    int n_assert;
    int n_fail;

    localparam logic [1:0] M_I = 2'd0, M_S = 2'd1, M_E = 2'd2, M_M = 2'd3;
    localparam logic [1:0] NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2;

    snoop_responder_if bus ();

    snoop_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .cnt_hit   (cnt_hit),
        .cnt_hitm  (cnt_hitm),
        .cnt_nohit (cnt_nohit)
`ifdef SNOOP_CHECK_EN
        ,
        .proto_err (proto_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snoop(input logic [3:0] op, input logic [31:0] addr);
        bus.snoop_valid = 1'b1;
        bus.snoop_op    = op;
        bus.snoop_addr  = addr;
        tick();
        bus.snoop_valid = 1'b0;
    endtask

    task automatic lookup(input logic hit, input logic [2:0] way, input logic [1:0] mesi);
        bus.lookup_ack  = 1'b1;
        bus.lookup_hit  = hit;
        bus.lookup_way  = way;
        bus.lookup_mesi = mesi;
        tick();
        bus.lookup_ack  = 1'b0;
        bus.lookup_hit  = 1'b0;
        bus.lookup_mesi = M_I;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.snoop_valid = 1'b0; bus.snoop_op = 4'd0; bus.snoop_addr = 32'd0;
        bus.lookup_ack = 1'b0; bus.lookup_hit = 1'b0; bus.lookup_way = 3'd0;
        bus.lookup_mesi = M_I; bus.wb_ack = 1'b0;
        tick(); tick();
        check("rst_lookup_req", bus.lookup_req, 0);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_wb_req", bus.wb_req, 0);
        check("rst_upd_valid", bus.upd_valid, 0);
        check("rst_counters", {cnt_hit, cnt_hitm}, 0);
        check("rst_cnt_nohit", cnt_nohit, 0);
`ifdef SNOOP_CHECK_EN
        check("rst_proto_err", proto_err, 0);
`endif
        rst = 1'b1;
        tick();
        check("ready_after_rst", bus.snoop_ready, 1);

        // Read miss
        snoop(4'd3, 32'h984DE132);
        check("miss_lookup_req", bus.lookup_req, 1);
        check("miss_ready_low", bus.snoop_ready, 0);
        check("miss_index", bus.lookup_index, 32'h3784);
        check("miss_tag", bus.lookup_tag, 32'h984);
        lookup(1'b0, 3'd0, M_I);
        check("miss_result_valid", bus.result_valid, 1);
        check("miss_result", bus.snoop_result, NOHIT);
        check("miss_no_upd", bus.upd_valid, 0);
        tick();
        check("miss_ready", bus.snoop_ready, 1);
        check("miss_no_upd2", bus.upd_valid, 0);
        check("miss_cnt_nohit", cnt_nohit, 1);

        // Read hit M: HITM, writeback held 3 cycles, update to S
        snoop(4'd3, 32'h984DE132);
        lookup(1'b1, 3'd5, M_M);
        check("hitm_result_valid", bus.result_valid, 1);
        check("hitm_result", bus.snoop_result, HITM);
        check("hitm_no_wb_yet", bus.wb_req, 0);
        tick();
        check("hitm_wb_req1", bus.wb_req, 1);
        check("hitm_wb_addr1", bus.wb_addr, 32'h984DE100);
        check("hitm_no_upd_in_wb", bus.upd_valid, 0);
        tick();
        check("hitm_wb_req2", bus.wb_req, 1);
        tick();
        check("hitm_wb_req3", bus.wb_req, 1);
        check("hitm_wb_addr3", bus.wb_addr, 32'h984DE100);
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        check("hitm_wb_dropped", bus.wb_req, 0);
        check("hitm_upd_valid", bus.upd_valid, 1);
        check("hitm_upd_way", bus.upd_way, 5);
        check("hitm_upd_mesi", bus.upd_mesi, M_S);
        tick();
        check("hitm_ready", bus.snoop_ready, 1);
        check("hitm_upd_once", bus.upd_valid, 0);
        check("hitm_cnt", cnt_hitm, 1);

        // RWIM hit E: HIT, update to I, no writeback
        snoop(4'd5, 32'h12345678);
        check("rwim_index", bus.lookup_index, 32'h1159);
        lookup(1'b1, 3'd2, M_E);
        check("rwim_result", bus.snoop_result, HIT);
        check("rwim_result_valid", bus.result_valid, 1);
        tick();
        check("rwim_no_wb", bus.wb_req, 0);
        check("rwim_upd_valid", bus.upd_valid, 1);
        check("rwim_upd_way", bus.upd_way, 2);
        check("rwim_upd_mesi", bus.upd_mesi, M_I);
        tick();
        check("rwim_ready", bus.snoop_ready, 1);
        check("rwim_cnt_hit", cnt_hit, 1);

        // Read hit S: HIT, no update
        snoop(4'd3, 32'h00000040);
        lookup(1'b1, 3'd1, M_S);
        check("reads_result", bus.snoop_result, HIT);
        tick();
        check("reads_ready", bus.snoop_ready, 1);
        check("reads_no_upd", bus.upd_valid, 0);
        check("reads_cnt_hit", cnt_hit, 2);

        // Snoop write: no lookup, NOHIT at T+1
        snoop(4'd4, 32'h116DE12F);
        check("wr_no_lookup", bus.lookup_req, 0);
        check("wr_result_valid", bus.result_valid, 1);
        check("wr_result", bus.snoop_result, NOHIT);
        tick();
        check("wr_ready", bus.snoop_ready, 1);
        check("wr_cnt_nohit", cnt_nohit, 2);

        // Invalidate hitting M: protocol violation, NOHIT, no update
        snoop(4'd6, 32'hABCDE000);
        lookup(1'b1, 3'd3, M_M);
        check("inv_result", bus.snoop_result, NOHIT);
        tick();
        check("inv_ready", bus.snoop_ready, 1);
        check("inv_no_upd", bus.upd_valid, 0);
        check("inv_cnt_nohit", cnt_nohit, 3);
`ifdef SNOOP_CHECK_EN
        check("inv_proto_err", proto_err, 1);
`endif

        // Unknown op is consumed with no outputs
        snoop(4'd9, 32'h0);
        check("unk_ready", bus.snoop_ready, 1);
        check("unk_no_lookup", bus.lookup_req, 0);
        check("unk_no_result", bus.result_valid, 0);
        tick();
        check("unk_no_result2", bus.result_valid, 0);
`ifdef SNOOP_CHECK_EN
        check("err_sticky", proto_err, 1);
`endif

        // Reset while in WRITEBACK aborts the transaction
        snoop(4'd3, 32'h984DE132);
        lookup(1'b1, 3'd4, M_M);
        tick();
        check("abort_in_wb", bus.wb_req, 1);
        rst = 1'b0;
        tick();
        check("abort_wb_dropped", bus.wb_req, 0);
        check("abort_no_upd", bus.upd_valid, 0);
        check("abort_counters", {cnt_hit, cnt_hitm}, 0);
        check("abort_cnt_nohit", cnt_nohit, 0);
`ifdef SNOOP_CHECK_EN
        check("abort_proto_err", proto_err, 0);
`endif
        rst = 1'b1;
        tick();
        check("abort_ready", bus.snoop_ready, 1);
        check("abort_no_upd2", bus.upd_valid, 0);
        check("abort_no_result", bus.result_valid, 0);
        tick();
        check("abort_idle_wb", bus.wb_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/snoop_responder.md
# snoop_responder

Services snooped bus operations from other processors against the data cache's MESI state. It accepts one snoop command (trace codes 3–6) per transaction and looks up the matching line through the data cache's tag-lookup port. It drives the snoop result (NOHIT/HIT/HITM) onto the bus, writes back modified data, and commits the resulting MESI transition. It sits beside `mesi_fsm` between the bus model and the 8-way data cache, and is the responder for requests that other caches' processor-side logic initiates.

## Interface
- `sets`, 16384, number of data-cache sets; index width `$clog2(sets)` = 14.
- `ways`, 8, data-cache associativity; way width `$clog2(ways)` = 3.
- `line_bytes`, 64, line size; offset width 6; tag width = 32 − index − offset = 12.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous active-low reset: sampled at `clk` rise, and low forces reset.
- `snoop_valid`  input  1  snoop command present.
- `snoop_op`  input  4  trace code `n`: 3 = snooped read, 4 = snooped write, 5 = snooped RWIM, 6 = snooped invalidate.
- `snoop_addr`  input  32  snooped byte address.
- `snoop_ready`  output  1  high only in IDLE.
- `lookup_req`  output  1  tag lookup request.
- `lookup_index`  output  14  `snoop_addr[19:6]`, latched.
- `lookup_tag`  output  12  `snoop_addr[31:20]`, latched.
- `lookup_ack`  input  1  lookup result valid.
- `lookup_hit`, `lookup_way[2:0]`, `lookup_mesi[1:0]`  inputs  lookup results; MESI encoding uses the shared package's M/E/S/I type.
- `result_valid`  output  1  one-cycle snoop-result strobe.
- `snoop_result`  output  2  0 = NOHIT, 1 = HIT, 2 = HITM.
- `wb_req`  output  1  writeback request.
- `wb_addr`  output  32  `{tag, index, 6'b0}`.
- `wb_ack`  input  1  writeback accepted.
- `upd_valid`  output  1  one-cycle MESI update strobe.
- `upd_way`  output  3  way to update.
- `upd_mesi`  output  2  new MESI state.
- `cnt_hit`, `cnt_hitm`, `cnt_nohit`  output  16 each  saturating result counters.
- `proto_err`  output  1  sticky protocol-error flag; present only with `SNOOP_CHECK_EN`.

## Operation
- States: IDLE, LOOKUP, RESPOND, WRITEBACK, UPDATE.
- IDLE: a handshake occurs when `snoop_valid && snoop_ready`. The block latches op, tag and index.
  - Ops 3, 5 and 6 go to LOOKUP.
  - Op 4 goes directly to RESPOND with NOHIT and makes no cache access.
  - Any other op is consumed and dropped with no outputs; the block stays in IDLE.
- LOOKUP: `lookup_req` is held until `lookup_ack`. The block latches hit, way and mesi.
- Result and next-state rules; a miss or I is treated identically (NOHIT, no update):
  - Read (3): M → HITM, writeback, then S. E → HIT, then S. S → HIT, no update.
  - RWIM (5): M → HITM, writeback, then I. E or S → HIT, then I.
  - Invalidate (6): S → HIT, then I. E or M is a protocol violation: NOHIT, no update.
- RESPOND: `result_valid` pulses for 1 cycle and the matching counter increments, saturating at 0xFFFF. The next state is WRITEBACK if HITM, UPDATE if the MESI state changes, otherwise IDLE.
- WRITEBACK: `wb_req` is held with a stable `wb_addr` until `wb_ack`, then goes to UPDATE.
- UPDATE: `upd_valid` pulses for 1 cycle, then returns to IDLE.

## Timing
- All outputs are registered or decoded from state. No combinational path exists from any input to `snoop_ready`.
- Handshake at cycle T: `lookup_req` is high at T+1. An ack in the same cycle puts RESPOND at T+2.
  - No change: back in IDLE with `snoop_ready` = 1 at T+3.
  - With a state change: UPDATE at T+3, IDLE at T+4.
  - HITM: add the cycles spent waiting for `wb_ack`, plus 1.
- Snoop result always precedes the writeback, and the writeback always precedes the MESI update.
- Reset values: IDLE, all strobes and requests 0, counters 0, `proto_err` 0. `snoop_ready` = 1 in the first cycle after `rst` is sampled high.
- Reset mid-transaction aborts immediately. No result, update or writeback strobe is emitted afterward, and `wb_req` drops in the reset cycle.
- Inputs `snoop_valid`/`snoop_op`/`snoop_addr` are ignored outside IDLE.

## Configuration
- `SNOOP_CHECK_EN` defined:
  - `proto_err` is set on an invalidate that hits E or M, on an E/M hit reported with no valid way, and on an unknown `snoop_op`.
  - It stays set until reset and issues `$error` in simulation.
- `SNOOP_CHECK_EN` undefined: the port and logic are absent. Response behaviour is otherwise identical.

## Test plan
- Reset, then snoop read 3 / 0x984DE132 with lookup miss → `lookup_index`=0x3784, `lookup_tag`=0x984; NOHIT at T+2; no `upd_valid`; `cnt_nohit`=1.
- Snoop read, hit way 5 in M → HITM; `wb_req` with `wb_addr`=0x984DE100 held for 3 cycles until `wb_ack`; then `upd_valid` with way 5, S.
- RWIM 5, hit way 2 in E → HIT, then update way 2 to I; no `wb_req`.
- Snoop write 4 / 0x116DE12F → no `lookup_req`; NOHIT at T+1; ready again at T+2.
- Invalidate 6 hitting M, built with `SNOOP_CHECK_EN` → NOHIT, no update, `proto_err`=1, which persists until `rst`=0.
- Assert `rst`=0 while in WRITEBACK → `wb_req` is 0 next cycle, no `upd_valid`, all counters 0, `snoop_ready`=1 after release.
